// File: rtl/gb_irq_ctrl_if.sv
// MMIO register port shared by the Game Boy peripheral blocks.
interface mem_if;
    logic [15:0] addr_select;
    logic        write_enable;
    logic [7:0]  write_value;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_enable,
        output write_value,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_enable,
        input  write_value,
        output read_out
    );
endinterface

// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, fixed-priority offer/ack to the CPU, wake line.
// Optional IRQ_EDGE_DETECT_EN: IF bits set on rising edges of the sources instead of levels.
module gb_irq_ctrl #(
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_if.slave        req,
    input  logic        irq_vblank,
    input  logic        irq_stat,
    input  logic        irq_timer,
    input  logic        irq_serial,
    input  logic        irq_joypad,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    input  logic        irq_ack,
    output logic        wake
);
    localparam int unsigned NSRC  = 5;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [NSRC-1:0]    if_q, if_nxt;
    logic [7:0]         ie_q;
    logic [CNT_W-1:0]   if_cnt, ie_cnt;
    logic [IDX_W-1:0]   idx_q, idx_nxt, win_idx;
    logic [15:0]        vec_nxt;
    logic               req_nxt;
    logic [NSRC-1:0]    src, set, pending, clr_mask;
    logic               if_hit, ie_hit, if_load, ie_load, ack_clr;

    assign src = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};

`ifdef IRQ_EDGE_DETECT_EN
    // Sources are registered twice; a rising edge of the registered copy sets IF.
    logic [NSRC-1:0] src_q, src_qq;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= '0;
            src_qq <= '0;
        end else begin
            src_q  <= src;
            src_qq <= src_q;
        end
    end

    assign set = src_q & ~src_qq;
`else
    assign set = src;
`endif

    assign if_hit  = req.write_enable && (req.addr_select == IF_ADDR);
    assign ie_hit  = req.write_enable && (req.addr_select == IE_ADDR);
    assign if_load = if_hit && (if_cnt == CNT_W'(1));
    assign ie_load = ie_hit && (ie_cnt == CNT_W'(1));

    assign pending = if_q & ie_q[NSRC-1:0];
    assign wake    = |pending;
    assign ack_clr = (state == OFFER) && irq_ack;
    assign clr_mask = NSRC'(1) << idx_q;

    always_comb begin
        case (req.addr_select)
            IF_ADDR: req.read_out = {3'b111, if_q};
            IE_ADDR: req.read_out = ie_q;
            default: req.read_out = 8'haa;
        endcase
    end

    // Lowest pending index wins.
    always_comb begin
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending[i]) win_idx = IDX_W'(i);
        end
    end

    // Write, then ack clear, then hardware set: later terms override earlier ones.
    always_comb begin
        if_nxt = if_q;
        if (if_load) if_nxt = req.write_value[NSRC-1:0];
        if (ack_clr) if_nxt = if_nxt & ~clr_mask;
        if_nxt = if_nxt | set;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        vec_nxt   = irq_vector;
        req_nxt   = irq_req;
        case (state)
            IDLE: begin
                if (|pending) begin
                    idx_nxt   = win_idx;
                    vec_nxt   = VEC_BASE + 16'(32'(win_idx) * VEC_STRIDE);
                    req_nxt   = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (irq_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = RELEASE;
                end else if ((pending & clr_mask) == '0) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            RELEASE: begin
                if (!irq_ack) state_nxt = IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Write-hold counters saturate so a long write_enable cannot reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_cnt <= '0;
            ie_cnt <= '0;
        end else begin
            if_cnt <= !if_hit ? '0 : (if_cnt == '1) ? if_cnt : if_cnt + CNT_W'(1);
            ie_cnt <= !ie_hit ? '0 : (ie_cnt == '1) ? ie_cnt : ie_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_q       <= '0;
            ie_q       <= '0;
            state      <= IDLE;
            idx_q      <= '0;
            irq_req    <= 1'b0;
            irq_vector <= '0;
        end else begin
            if_q       <= if_nxt;
            if (ie_load) ie_q <= req.write_value;
            state      <= state_nxt;
            idx_q      <= idx_nxt;
            irq_req    <= req_nxt;
            irq_vector <= vec_nxt;
        end
    end
endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed scoreboard bench for gb_irq_ctrl (level-sensitive build).
module tb_gb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack;
    logic        wake;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];

    mem_if bus ();

    gb_irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.slave),
        .irq_vblank (irq_vblank),
        .irq_stat   (irq_stat),
        .irq_timer  (irq_timer),
        .irq_serial (irq_serial),
        .irq_joypad (irq_joypad),
        .irq_req    (irq_req),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .wake       (wake)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL scoreboard_empty: observed %h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic read_reg(input string tag, input logic [15:0] a, input logic [7:0] v);
        expect_val(tag, 16'(v));
        bus.addr_select = a;
        #1;
        check(16'(bus.read_out));
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [15:0] v);
        expect_val({tag, "_req"}, 16'(r));
        if (r) expect_val({tag, "_vec"}, v);
        check(16'(irq_req));
        if (r) check(irq_vector);
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [7:0] v);
        bus.addr_select  = a;
        bus.write_value  = v;
        bus.write_enable = 1'b1;
        repeat (3) tick();
        bus.write_enable = 1'b0;
        bus.addr_select  = 16'h0000;
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        {irq_vblank, irq_stat, irq_timer, irq_serial, irq_joypad, irq_ack} = '0;
        bus.addr_select  = 16'h0000;
        bus.write_enable = 1'b0;
        bus.write_value  = 8'h00;
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state and register map
        read_reg("rst_if", 16'hFF0F, 8'hE0);
        read_reg("rst_ie", 16'hFFFF, 8'h00);
        read_reg("unmapped", 16'hFF10, 8'haa);
        expect_req("rst", 1'b0, 16'h0000);
        expect_val("rst_wake", 16'h0); check(16'(wake));

        // 1b: a single-cycle write pulse never loads
        bus.addr_select = 16'hFFFF; bus.write_value = 8'h1F; bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
        tick();
        read_reg("short_write_ie", 16'hFFFF, 8'h00);

        // 2: timer interrupt, two-edge latency, ack clears
        mmio_write(16'hFFFF, 8'h04);
        read_reg("ie_04", 16'hFFFF, 8'h04);
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        read_reg("if_timer", 16'hFF0F, 8'hE4);
        expect_val("wake_timer", 16'h1); check(16'(wake));
        expect_req("timer_edge1", 1'b0, 16'h0000);
        tick();
        expect_req("timer_offer", 1'b1, 16'h0050);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        read_reg("if_after_ack", 16'hFF0F, 8'hE0);
        expect_req("timer_acked", 1'b0, 16'h0000);
        tick();

        // 3: simultaneous VBlank and serial, priority order
        mmio_write(16'hFFFF, 8'h1F);
        irq_serial = 1'b1; irq_vblank = 1'b1;
        tick();
        irq_serial = 1'b0; irq_vblank = 1'b0;
        tick();
        expect_req("prio_first", 1'b1, 16'h0040);
        ack_once();
        read_reg("if_serial_left", 16'hFF0F, 8'hE8);
        tick();
        expect_req("prio_second", 1'b1, 16'h0058);
        ack_once();

        // 4: masked joypad, then unmasked by IE write
        mmio_write(16'hFFFF, 8'h00);
        irq_joypad = 1'b1;
        tick();
        irq_joypad = 1'b0;
        tick();
        tick();
        read_reg("if_joypad", 16'hFF0F, 8'hF0);
        expect_val("wake_masked", 16'h0); check(16'(wake));
        expect_req("joypad_masked", 1'b0, 16'h0000);
        mmio_write(16'hFFFF, 8'h10);
        expect_req("joypad_offer", 1'b1, 16'h0060);
        ack_once();

        // 5a: CPU clears IF while offering, request is withdrawn
        mmio_write(16'hFFFF, 8'h04);
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        tick();
        expect_req("withdraw_pre", 1'b1, 16'h0050);
        mmio_write(16'hFF0F, 8'h00);
        expect_req("withdrawn", 1'b0, 16'h0000);
        read_reg("if_withdrawn", 16'hFF0F, 8'hE0);

        // 5b: hardware set beats a same-edge IF write
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        tick();
        bus.addr_select = 16'hFF0F; bus.write_value = 8'h00; bus.write_enable = 1'b1;
        tick();
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        bus.write_enable = 1'b0;
        read_reg("set_beats_write", 16'hFF0F, 8'hE4);
        tick();
        expect_req("still_offered", 1'b1, 16'h0050);
        ack_once();

        // 6: long ack, one clear only, new offer after ack falls
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        tick();
        expect_req("long_ack_offer", 1'b1, 16'h0050);
        irq_ack = 1'b1;
        tick();
        read_reg("long_ack_clear", 16'hFF0F, 8'hE0);
        irq_timer = 1'b1;
        tick();
        irq_timer = 1'b0;
        tick();
        tick();
        read_reg("one_clear_only", 16'hFF0F, 8'hE4);
        expect_req("ack_held", 1'b0, 16'h0000);
        irq_ack = 1'b0;
        tick();
        expect_req("release_idle", 1'b0, 16'h0000);
        tick();
        expect_req("reoffer", 1'b1, 16'h0050);

        // 6b: reset mid-offer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_req("rst_offer", 1'b0, 16'h0000);
        read_reg("rst_if2", 16'hFF0F, 8'hE0);
        read_reg("rst_ie2", 16'hFFFF, 8'h00);
        expect_val("rst_wake2", 16'h0); check(16'(wake));
        tick();
        expect_req("rst_stays_idle", 1'b0, 16'h0000);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
